// File: rtl/cpl_tag_manager_pkg.sv
// cpl_tag_manager_pkg: shared constants, CTO table, sweep states and width helper
package cpl_tag_manager_pkg;

    // Completion Timeout Value encodings; each range has a low and a high sub-range
    localparam logic [3:0] CTO_DEFAULT = 4'b0000;
    localparam logic [3:0] CTO_A_LO    = 4'b0001;
    localparam logic [3:0] CTO_A_HI    = 4'b0010;
    localparam logic [3:0] CTO_B_LO    = 4'b0101;
    localparam logic [3:0] CTO_B_HI    = 4'b0110;
    localparam logic [3:0] CTO_C_LO    = 4'b1001;
    localparam logic [3:0] CTO_C_HI    = 4'b1010;
    localparam logic [3:0] CTO_D_LO    = 4'b1101;
    localparam logic [3:0] CTO_D_HI    = 4'b1110;

    // Toggle bit used when the field is zero or reserved (8ns counter base)
    localparam logic [4:0] CTO_DEFAULT_BIT = 5'd21;

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} sweep_state_t;

    // Tracker toggle-bit index for a CTO code, 8ns base clock
    function automatic logic [4:0] cto_bit_idx(input logic [3:0] cfg);
        case (cfg)
            CTO_A_LO: return 5'd13;
            CTO_A_HI: return 5'd19;
            CTO_B_LO: return 5'd21;
            CTO_B_HI: return 5'd23;
            CTO_C_LO: return 5'd25;
            CTO_C_HI: return 5'd27;
            CTO_D_LO: return 5'd29;
            CTO_D_HI: return 5'd31;
            default:  return CTO_DEFAULT_BIT;
        endcase
    endfunction

    // Bits needed to index n entries
    function automatic int tag_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/cpl_tag_manager_pe.sv
// cpl_tag_pe: lowest-index free tag priority encoder with full flag
module cpl_tag_pe #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [N-1:0] busy,
    output logic [W-1:0] free_tag,
    output logic         all_busy
);

    // Scan from the top so the lowest clear bit wins
    always_comb begin
        free_tag = '0;
        for (int i = N - 1; i >= 0; i--)
            if (!busy[i]) free_tag = W'(i);
    end

    assign all_busy = &busy;

endmodule

// File: rtl/cpl_tag_manager.sv
// cpl_tag_manager: requester tag pool, CTO bit select and completion-timeout sweep
module cpl_tag_manager
    import cpl_tag_manager_pkg::*;
#(
    parameter int ENTRY_COUNT   = 64,
    parameter int COUNTER_WIDTH = 32,
    parameter int TAG_WIDTH     = tag_width(ENTRY_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               cto_cfg,
    input  logic                     alloc_req,
    output logic                     alloc_gnt,
    output logic [TAG_WIDTH-1:0]     alloc_tag,
    input  logic                     cpl_valid,
    input  logic [TAG_WIDTH-1:0]     cpl_tag,
    output logic                     spurious_cpl,
    output logic                     to_add_entry,
    output logic [TAG_WIDTH-1:0]     to_add_entry_tag,
    output logic [COUNTER_WIDTH-1:0] to_bit_select,
    output logic [TAG_WIDTH-1:0]     to_query_tag,
    input  logic                     to_entry_timeout,
    output logic                     timeout_valid,
    output logic [TAG_WIDTH-1:0]     timeout_tag,
    input  logic                     timeout_ready,
    output logic [TAG_WIDTH:0]       outstanding_cnt,
    output logic                     all_busy
);

    localparam int CNT_W = TAG_WIDTH + 1;

    logic [ENTRY_COUNT-1:0] busy, busy_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [TAG_WIDTH-1:0]   scan_ptr, scan_ptr_nxt, free_tag;
    sweep_state_t           state, state_nxt;
    logic                   pe_full, cpl_hit, rpt_hs, detect;

    cpl_tag_pe #(.N(ENTRY_COUNT), .W(TAG_WIDTH)) u_pe (
        .busy     (busy),
        .free_tag (free_tag),
        .all_busy (pe_full)
    );

    assign all_busy         = pe_full;
    assign alloc_gnt        = rst_n & alloc_req & ~pe_full;
    assign alloc_tag        = free_tag;
    assign to_add_entry     = alloc_gnt;
    assign to_add_entry_tag = free_tag;
    assign to_query_tag     = scan_ptr;
    assign timeout_valid    = (state == REPORT);
    assign rpt_hs           = timeout_valid & timeout_ready;
    // The tag under report belongs to the error path; a completion for it is dropped
    assign cpl_hit = cpl_valid & busy[cpl_tag] & ~(timeout_valid & (cpl_tag == timeout_tag));
    // A completion arriving in the detect cycle beats the timeout
    assign detect  = busy[scan_ptr] & to_entry_timeout & ~(cpl_valid & (cpl_tag == scan_ptr));

    // Next busy map and count: grant sets, completion and report handshake clear
    always_comb begin
        busy_nxt = busy;
        if (alloc_gnt) busy_nxt[free_tag] = 1'b1;
        if (cpl_hit) busy_nxt[cpl_tag] = 1'b0;
        if (rpt_hs) busy_nxt[timeout_tag] = 1'b0;
        cnt_nxt = outstanding_cnt + CNT_W'(alloc_gnt) - CNT_W'(cpl_hit) - CNT_W'(rpt_hs);
    end

    // Sweep next-state: walk busy tags, park on a timed-out one until accepted
    always_comb begin
        state_nxt    = state;
        scan_ptr_nxt = scan_ptr;
        case (state)
            IDLE:   if (outstanding_cnt != '0) state_nxt = SCAN;
            SCAN: begin
                if (outstanding_cnt == '0) state_nxt = IDLE;
                else if (detect) state_nxt = REPORT;
                else scan_ptr_nxt = scan_ptr + 1'b1;
            end
            REPORT: begin
                if (timeout_ready) begin
                    state_nxt    = SCAN;
                    scan_ptr_nxt = scan_ptr + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tag pool state and spurious-completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= '0;
            outstanding_cnt <= '0;
            spurious_cpl    <= 1'b0;
        end else begin
            busy            <= busy_nxt;
            outstanding_cnt <= cnt_nxt;
            spurious_cpl    <= cpl_valid & ~cpl_hit;
        end
    end

    // Sweep state, pointer and latched report tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            scan_ptr    <= '0;
            timeout_tag <= '0;
        end else begin
            state    <= state_nxt;
            scan_ptr <= scan_ptr_nxt;
            if (state == SCAN && state_nxt == REPORT) timeout_tag <= scan_ptr;
        end
    end

    // One-hot tracker bit select, one cycle behind the config field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_bit_select <= COUNTER_WIDTH'(1) << CTO_DEFAULT_BIT;
        else        to_bit_select <= COUNTER_WIDTH'(1) << cto_bit_idx(cto_cfg);
    end

endmodule

// File: tb/tb_cpl_tag_manager.sv
// tb_cpl_tag_manager: randomized and directed checks against a tag-pool model
module tb_cpl_tag_manager;

    localparam int N  = 64;
    localparam int TW = 6;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    cto_cfg = 4'b0000;
    logic          alloc_req = 1'b0;
    logic          cpl_valid = 1'b0;
    logic [TW-1:0] cpl_tag = '0;
    logic          timeout_ready = 1'b0;
    logic          to_entry_timeout;
    logic          alloc_gnt, spurious_cpl, to_add_entry, timeout_valid, all_busy;
    logic [TW-1:0] alloc_tag, to_add_entry_tag, to_query_tag, timeout_tag;
    logic [CW-1:0] to_bit_select;
    logic [TW:0]   outstanding_cnt;

    int passed = 0;
    int total  = 0;

    cpl_tag_manager dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cto_cfg          (cto_cfg),
        .alloc_req        (alloc_req),
        .alloc_gnt        (alloc_gnt),
        .alloc_tag        (alloc_tag),
        .cpl_valid        (cpl_valid),
        .cpl_tag          (cpl_tag),
        .spurious_cpl     (spurious_cpl),
        .to_add_entry     (to_add_entry),
        .to_add_entry_tag (to_add_entry_tag),
        .to_bit_select    (to_bit_select),
        .to_query_tag     (to_query_tag),
        .to_entry_timeout (to_entry_timeout),
        .timeout_valid    (timeout_valid),
        .timeout_tag      (timeout_tag),
        .timeout_ready    (timeout_ready),
        .outstanding_cnt  (outstanding_cnt),
        .all_busy         (all_busy)
    );

    always #4 clk = ~clk;

    // Behavioural tracker: an entry times out thr cycles after it was added
    int unsigned cyc = 0;
    int unsigned thr = 1000000;
    int unsigned trk_t [N];
    bit          trk_v [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) trk_v[i] <= 1'b0;
        end else if (to_add_entry) begin
            trk_v[to_add_entry_tag] <= 1'b1;
            trk_t[to_add_entry_tag] <= cyc + 1;
        end
    end

    function automatic bit trk_to(input int t);
        return trk_v[t] && (cyc - trk_t[t]) >= thr;
    endfunction

    always_comb to_entry_timeout = trk_v[to_query_tag] && (cyc - trk_t[to_query_tag]) >= thr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [4:0] cfg_bit(input logic [3:0] c);
        case (c)
            4'b0001: return 5'd13;
            4'b0010: return 5'd19;
            4'b0101: return 5'd21;
            4'b0110: return 5'd23;
            4'b1001: return 5'd25;
            4'b1010: return 5'd27;
            4'b1101: return 5'd29;
            4'b1110: return 5'd31;
            default: return 5'd21;
        endcase
    endfunction

    // Model state: set of busy tags, count, pending pulse, expected bit select
    bit          mb [N];
    int          mcnt;
    bit          mspur;
    logic [31:0] mbs;
    bit          pv, prdy;
    logic [TW-1:0] ptag;
    int          age [N];

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!mb[i]) return i;
        return 0;
    endfunction

    function automatic int pick_busy();
        int s;
        s = $urandom % N;
        for (int k = 0; k < N; k++) if (mb[(s + k) % N]) return (s + k) % N;
        return s;
    endfunction

    // Compare process: check every cycle mid-period, then advance the model across the edge
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin mb[i] = 1'b0; age[i] = 0; end
            mcnt = 0; mspur = 1'b0; mbs = 32'h0020_0000; pv = 1'b0; prdy = 1'b0; ptag = '0;
        end else begin
            bit full, gnt, rep, hs, cf;
            int et, max_age;
            full = (mcnt == N);
            gnt  = alloc_req && !full;
            et   = lowest_free();
            chk("outstanding_cnt", outstanding_cnt, mcnt);
            chk("all_busy", all_busy, full);
            chk("alloc_gnt", alloc_gnt, gnt);
            chk("to_add_entry", to_add_entry, gnt);
            if (gnt) begin
                chk("alloc_tag", alloc_tag, et);
                chk("to_add_entry_tag", to_add_entry_tag, et);
            end
            chk("spurious_cpl", spurious_cpl, mspur);
            chk("to_bit_select", to_bit_select, mbs);
            if (pv && !prdy) begin
                chk("report_held", timeout_valid, 1);
                chk("report_stable", timeout_tag, ptag);
            end
            if (timeout_valid) begin
                chk("report_tag_busy", mb[timeout_tag], 1);
                chk("report_tag_timed_out", trk_to(timeout_tag), 1);
            end
            max_age = 0;
            for (int i = 0; i < N; i++) begin
                if (!(mb[i] && trk_to(i))) age[i] = 0;
                else if (!timeout_valid) age[i]++;
                if (age[i] > max_age) max_age = age[i];
            end
            chk("report_latency_exceeded", max_age > N + 3, 0);
            rep = timeout_valid;
            hs  = rep && timeout_ready;
            cf  = cpl_valid && mb[cpl_tag] && !(rep && cpl_tag == timeout_tag);
            mspur = cpl_valid && !cf;
            if (gnt) mb[et] = 1'b1;
            if (cf) mb[cpl_tag] = 1'b0;
            if (hs) mb[timeout_tag] = 1'b0;
            mcnt = mcnt + int'(gnt) - int'(cf) - int'(hs);
            mbs  = 32'd1 << cfg_bit(cto_cfg);
            pv = rep; prdy = timeout_ready; ptag = timeout_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        // Reset values, grant suppressed while in reset
        alloc_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_alloc_gnt", alloc_gnt, 0);
        chk("rst_to_add_entry", to_add_entry, 0);
        chk("rst_outstanding", outstanding_cnt, 0);
        chk("rst_all_busy", all_busy, 0);
        chk("rst_bit_select", to_bit_select, 32'h0020_0000);
        chk("rst_timeout_valid", timeout_valid, 0);
        chk("rst_timeout_tag", timeout_tag, 0);
        chk("rst_spurious", spurious_cpl, 0);
        chk("rst_query_tag", to_query_tag, 0);
        alloc_req = 1'b0;
        tick();
        rst_n = 1'b1;

        // CTO mapping, one cycle latency
        cto_cfg = 4'b0001; tick(); #1 chk("cfg_0001", to_bit_select, 32'h0000_2000);
        cto_cfg = 4'b1110; tick(); #1 chk("cfg_1110", to_bit_select, 32'h8000_0000);
        cto_cfg = 4'b0011; tick(); #1 chk("cfg_0011", to_bit_select, 32'h0020_0000);

        // Fill the pool back to back
        alloc_req = 1'b1;
        for (int i = 0; i < N; i++) begin
            #1 chk("fill_gnt", alloc_gnt, 1);
            chk("fill_tag", alloc_tag, i);
            tick();
        end
        #1 chk("full_gnt", alloc_gnt, 0);
        chk("full_all_busy", all_busy, 1);
        chk("full_cnt", outstanding_cnt, 64);

        // Free tag 5 while full: not grantable until the next cycle
        cpl_valid = 1'b1; cpl_tag = 6'd5;
        #1 chk("free5_same_cycle_gnt", alloc_gnt, 0);
        tick();
        cpl_valid = 1'b0;
        #1 chk("free5_next_gnt", alloc_gnt, 1);
        chk("free5_next_tag", alloc_tag, 5);
        tick();
        alloc_req = 1'b0;
        #1 chk("free5_cnt", outstanding_cnt, 64);

        // Drain all tags
        for (int t = 0; t < N; t++) begin
            cpl_valid = 1'b1; cpl_tag = TW'(t); tick();
        end
        cpl_valid = 1'b0;
        #1 chk("drain_cnt", outstanding_cnt, 0);

        // Completion for a free tag
        cpl_valid = 1'b1; cpl_tag = 6'd7; tick();
        cpl_valid = 1'b0;
        #1 chk("spurious_pulse", spurious_cpl, 1);
        chk("spurious_cnt", outstanding_cnt, 0);
        tick();
        #1 chk("spurious_one_cycle", spurious_cpl, 0);

        // Timeout of tag 3 with the 0001 range
        cto_cfg = 4'b0001; tick();
        thr = 8192 + $urandom_range(1, 8191);
        alloc_req = 1'b1; repeat (4) tick(); alloc_req = 1'b0;
        n = 0;
        for (int t = 0; t < 3; t++) begin
            cpl_valid = 1'b1; cpl_tag = TW'(t); tick(); n++;
        end
        cpl_valid = 1'b0;
        while (!timeout_valid && n < 20000) begin tick(); n++; end
        chk("to_seen", timeout_valid, 1);
        chk("to_tag", timeout_tag, 3);
        chk("to_latency_window", (n >= 8193 && n <= 16448), 1);
        timeout_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1 chk("to_hold_valid", timeout_valid, 1);
            chk("to_hold_tag", timeout_tag, 3);
        end
        timeout_ready = 1'b1;
        #1 chk("to_pre_hs_cnt", outstanding_cnt, 1);
        tick();
        timeout_ready = 1'b0;
        #1 chk("to_post_hs_cnt", outstanding_cnt, 0);
        chk("to_post_hs_valid", timeout_valid, 0);
        thr = 1000000;

        // Completion in the detect cycle wins over the timeout
        thr = 6;
        alloc_req = 1'b1; tick(); alloc_req = 1'b0;
        n = 0;
        while (!(to_entry_timeout && to_query_tag == 0) && n < 300) begin tick(); n++; end
        chk("race_detect_found", to_entry_timeout && to_query_tag == 0, 1);
        cpl_valid = 1'b1; cpl_tag = 6'd0; tick();
        cpl_valid = 1'b0;
        #1 chk("race_no_report", timeout_valid, 0);
        chk("race_cnt", outstanding_cnt, 0);
        tick();
        #1 chk("race_no_spurious", spurious_cpl, 0);
        chk("race_still_no_report", timeout_valid, 0);

        // Randomized traffic with a mid-run reset
        thr = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #1 rst_n = 1'b0;
                #1 chk("midrst_cnt", outstanding_cnt, 0);
                chk("midrst_valid", timeout_valid, 0);
                chk("midrst_gnt", alloc_gnt, 0);
                tick();
                rst_n = 1'b1;
            end
            alloc_req     = ($urandom % 3) != 0;
            timeout_ready = ($urandom % 3) == 0;
            cpl_valid     = ($urandom % 5) < 2;
            case ($urandom % 6)
                0:       cpl_tag = TW'($urandom);
                1:       cpl_tag = timeout_valid ? timeout_tag : TW'(pick_busy());
                2:       cpl_tag = to_query_tag;
                default: cpl_tag = TW'(pick_busy());
            endcase
            if (outstanding_cnt == 0 && ($urandom % 4) == 0) cto_cfg = 4'($urandom);
            tick();
        end
        alloc_req = 1'b0; cpl_valid = 1'b0; timeout_ready = 1'b1;
        n = 0;
        while (outstanding_cnt != 0 && n < 2000) begin
            cpl_valid = 1'b1; cpl_tag = TW'(pick_busy());
            tick(); n++;
        end
        cpl_valid = 1'b0;
        #1 chk("final_drain_cnt", outstanding_cnt, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
